// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator answering a host start pulse with ack and 40-bit frame
module dht11_responder #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_LOW_US    = 80,
    parameter int ACK_HIGH_US   = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dq_in,
    output logic       dq_oe,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START_LOW, S_RESP_DELAY, S_ACK_LOW,
        S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [PW-1:0] pre_q;
    logic [14:0]   us_q;
    logic [39:0]   shift_q, shift_d;
    logic [5:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          tick;
    logic          line;
    logic [7:0]    checksum;
    logic [31:0]   us_seen;

    // True on the tick that completes n microseconds in the current state.
    function automatic logic elapsed(input logic [14:0] cnt, input logic t, input int n);
        return t && (({17'd0, cnt} + 32'd1) == 32'(n));
    endfunction

    assign line       = sync2_q;
    assign tick       = (pre_q == PW'(CLKS_PER_US - 1));
    assign checksum   = humid_int + humid_dec + temp_int + temp_dec;
    // Includes the tick landing on the release edge, so an exact START_MIN_US pulse is accepted.
    assign us_seen    = {17'd0, us_q} + (tick ? 32'd1 : 32'd0);
    assign busy       = !(state_q == S_IDLE || state_q == S_START_LOW);
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        dq_oe   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!line) state_d = S_START_LOW;
            end
            S_START_LOW: begin
                if (line) begin
                    if (us_seen >= 32'(START_MIN_US)) begin
                        state_d = S_RESP_DELAY;
                        shift_d = {humid_int, humid_dec, temp_int, temp_dec, checksum};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESP_DELAY: begin
                if (elapsed(us_q, tick, RESP_DELAY_US)) state_d = S_ACK_LOW;
            end
            S_ACK_LOW: begin
                dq_oe = 1'b1;
                if (elapsed(us_q, tick, ACK_LOW_US)) state_d = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                if (elapsed(us_q, tick, ACK_HIGH_US)) begin
                    state_d = S_BIT_LOW;
                    idx_d   = 6'd0;
                end
            end
            S_BIT_LOW: begin
                dq_oe = 1'b1;
                if (elapsed(us_q, tick, BIT_LOW_US)) state_d = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (elapsed(us_q, tick, shift_q[39] ? BIT1_HIGH_US : BIT0_HIGH_US)) begin
                    shift_d = {shift_q[38:0], 1'b0};
                    idx_d   = idx_q + 6'd1;
                    state_d = (idx_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                dq_oe = 1'b1;
                if (elapsed(us_q, tick, BIT_LOW_US)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            pre_q   <= '0;
            us_q    <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= dq_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (state_d != state_q) begin
                pre_q <= '0;
                us_q  <= '0;
            end else begin
                pre_q <= tick ? '0 : pre_q + PW'(1);
                if (tick && (us_q != '1)) us_q <= us_q + 15'd1;
            end
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - self-checking bench for dht11_responder
module tb_dht11_responder;
    localparam int CPU  = 2;
    localparam int SMIN = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dq_in = 1'b1;
    logic [7:0] humid_int = 8'h00, humid_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
    logic       dq_oe, busy, frame_done;

    dht11_responder #(.CLKS_PER_US(CPU), .START_MIN_US(SMIN)) dut (
        .clk(clk), .reset(reset), .dq_in(dq_in), .dq_oe(dq_oe),
        .humid_int(humid_int), .humid_dec(humid_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected dq_oe runs (level, length in clocks) for frames in flight.
    bit          exp_lvl[$];
    int          exp_len[$];
    logic [39:0] exp_frames[$];
    bit          ack_pending = 1'b0;
    bit          ack_high_seen = 1'b0;
    int          rel_cyc = 0;
    logic [39:0] dec = '0;
    logic [39:0] last_frame = '0;
    int          bits_seen = 0;
    int          done_cnt = 0;
    bit          prev_oe = 1'b0;
    int          run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        int cs;
        logic [39:0] f;
        cs = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        f  = {a, b, c, d, 8'(cs)};
        exp_frames.push_back(f);
        exp_lvl.push_back(1'b1); exp_len.push_back(80 * CPU);
        exp_lvl.push_back(1'b0); exp_len.push_back(80 * CPU);
        for (int i = 39; i >= 0; i--) begin
            exp_lvl.push_back(1'b1); exp_len.push_back(50 * CPU);
            exp_lvl.push_back(1'b0); exp_len.push_back((f[i] ? 70 : 27) * CPU);
        end
        exp_lvl.push_back(1'b1); exp_len.push_back(50 * CPU);
        dec = '0;
        bits_seen = 0;
        ack_high_seen = 1'b0;
        rel_cyc = cyc;
        ack_pending = 1'b1;
    endtask

    always @(negedge clk) begin
        bit last_seg;
        last_seg = 1'b0;
        if (reset) begin
            exp_lvl.delete(); exp_len.delete(); exp_frames.delete();
            ack_pending = 1'b0;
            bits_seen = 0;
            prev_oe = dq_oe;
            run = 0;
        end else if (dq_oe !== prev_oe) begin
            if (ack_pending) begin
                check("ack_delay_in_window",
                      ((cyc - rel_cyc) >= 30 * CPU) && ((cyc - rel_cyc) <= 30 * CPU + 4), 1);
                check("busy_at_ack", busy, 1);
                ack_pending = 1'b0;
            end else if (exp_len.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_dq_oe_edge at cycle %0d: got dq_oe=%0b, required no activity", cyc, dq_oe);
            end else begin
                check("seg_level", prev_oe, exp_lvl[0]);
                check("seg_len", run, exp_len[0]);
                void'(exp_lvl.pop_front());
                void'(exp_len.pop_front());
                if (!prev_oe) begin
                    if (!ack_high_seen) ack_high_seen = 1'b1;
                    else begin
                        dec = {dec[38:0], run > 48 * CPU};
                        bits_seen++;
                    end
                end
                if (exp_len.size() == 0) begin
                    last_seg = 1'b1;
                    last_frame = dec;
                    if (exp_frames.size() > 0) check("frame_bits", dec, exp_frames.pop_front());
                end else begin
                    check("busy_mid_frame", busy, 1);
                end
            end
            run = 1;
            prev_oe = dq_oe;
        end else begin
            run++;
        end
        if (!reset && (frame_done || last_seg)) begin
            check("frame_done_timing", frame_done, last_seg);
            if (last_seg) check("busy_at_end", busy, 0);
        end
        if (frame_done) done_cnt++;
    end

    task automatic host_start(input int us);
        @(negedge clk);
        dq_in = 1'b0;
        repeat (us * CPU) @(negedge clk);
        dq_in = 1'b1;
    endtask

    task automatic wait_frame(input string name);
        int base;
        bit got;
        base = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 14000 && !got; i++) begin
            @(negedge clk);
            if (done_cnt > base) got = 1'b1;
        end
        check({name, "_completes"}, got, 1);
    endtask

    task automatic wait_bits(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 14000 && !got; i++) begin
            @(negedge clk);
            if (bits_seen >= n) got = 1'b1;
        end
        check("reached_bit", got, 1);
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        humid_int = a; humid_dec = b; temp_int = c; temp_dec = d;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [39:0] lit, input string name);
        set_inputs(a, b, c, d);
        host_start(SMIN);
        expect_frame(a, b, c, d);
        repeat (5) @(negedge clk);
        check({name, "_busy"}, busy, 1);
        wait_frame(name);
        check({name, "_literal"}, last_frame, lit);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("reset_dq_oe", dq_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        host_start(SMIN - 1);
        repeat (100) @(negedge clk);
        check("short_start_busy", busy, 0);

        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 40'h37_00_19_05_55, "frame_37");
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 40'hFF_FF_FF_FF_FC, "frame_ff");
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 40'h00_00_00_00_00, "frame_00");

        set_inputs(8'h01, 8'h02, 8'h03, 8'h04);
        host_start(SMIN);
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04);
        wait_bits(10);
        set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        wait_frame("frame_latched");
        check("frame_latched_literal", last_frame, 40'h01_02_03_04_0A);
        repeat (10) @(negedge clk);
        run_frame(8'hAA, 8'hAA, 8'hAA, 8'hAA, 40'hAA_AA_AA_AA_A8, "frame_aa");

        d0 = done_cnt;
        set_inputs(8'h5A, 8'h3C, 8'h81, 8'h7E);
        host_start(SMIN);
        expect_frame(8'h5A, 8'h3C, 8'h81, 8'h7E);
        wait_bits(20);
        dq_in = 1'b0;
        repeat (30 * CPU) @(negedge clk);
        dq_in = 1'b1;
        wait_frame("frame_host_glitch");
        check("frame_host_glitch_literal", last_frame, 40'h5A_3C_81_7E_95);
        run_frame(8'h5A, 8'h3C, 8'h81, 8'h7E, 40'h5A_3C_81_7E_95, "frame_back_to_back");
        check("done_pulse_count", done_cnt, d0 + 2);

        set_inputs(8'hC3, 8'h11, 8'h22, 8'h33);
        host_start(SMIN);
        expect_frame(8'hC3, 8'h11, 8'h22, 8'h33);
        wait_bits(5);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_dq_oe", dq_oe, 0);
        check("midreset_busy", busy, 0);
        check("midreset_frame_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("midreset_no_done", done_cnt, d0);

        run_frame(8'h12, 8'h34, 8'h56, 8'h78, 40'h12_34_56_78_14, "frame_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
